// File: rtl/vga_pipelined_controller.sv
// VGA raster generator with a divided pixel tick and a request/display lead.
// The request side (req_x/req_y/req_valid) runs LEAD pixel ticks ahead of the
// registered sync/DE/colour outputs, so a pixel source with LEAD ticks of
// latency can answer in time. Total request-to-output latency is LEAD+1 ticks.
module vga_pipelined_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 1,
  parameter int LEAD     = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 8,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [3*CW-1:0] color_in,
  output logic            req_valid,
  output logic [XW-1:0]   req_x,
  output logic [YW-1:0]   req_y,
  output logic            screenend,
  output logic [15:0]     frame_cnt,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [DW-1:0]   div_q, div_d;
  logic [XW-1:0]   h_q, h_d;
  logic [YW-1:0]   v_q, v_d;
  logic [15:0]     frame_q, frame_d;
  logic            pe, h_last, v_last;
  logic            hs_raw, vs_raw, valid_raw;
  logic [2:0]      cur_bits, dly_bits;
  logic            hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [3*CW-1:0] rgb_q, rgb_d;

  assign pe     = en && (div_q == DIV_LAST);
  assign h_last = (h_q == XW'(H_TOTAL - 1));
  assign v_last = (v_q == YW'(V_TOTAL - 1));

  assign valid_raw = (h_q < XW'(H_ACTIVE)) && (v_q < YW'(V_ACTIVE));
  assign hs_raw    = (h_q >= XW'(H_ACTIVE + H_FP)) && (h_q < XW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw    = (v_q >= YW'(V_ACTIVE + V_FP)) && (v_q < YW'(V_ACTIVE + V_FP + V_SYNC));
  assign cur_bits  = {hs_raw, vs_raw, valid_raw};

  assign req_valid = valid_raw;
  assign req_x     = h_q;
  assign req_y     = v_q;
  assign screenend = pe && h_last && v_last;

  // Next-state for the pixel divider and the H/V raster counters
  always_comb begin
    div_d   = div_q;
    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    if (!en) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else if (pe) begin
      div_d = '0;
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + YW'(1);
      end else begin
        h_d = h_q + XW'(1);
      end
    end else begin
      div_d = div_q + DW'(1);
    end
    if (screenend) frame_d = frame_q + 16'd1;
  end

  // Counter state register; frame count holds while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
    end
  end

  // LEAD-deep delay of {hs, vs, valid}; LEAD=0 passes the current counters through
  generate
    if (LEAD == 0) begin : g_nolead
      assign dly_bits = cur_bits;
    end else begin : g_lead
      logic [2:0] pipe_q [LEAD];
      // Shift on each pixel tick, flush to idle while disabled
      always_ff @(posedge clk or posedge rst) begin
        if (rst || !en) begin
          for (int i = 0; i < LEAD; i++) pipe_q[i] <= '0;
        end else if (pe) begin
          pipe_q[0] <= cur_bits;
          for (int i = 1; i < LEAD; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign dly_bits = pipe_q[LEAD-1];
    end
  endgenerate

  // Output next-state: polarity mapping and colour blanking
  always_comb begin
    hsync_d = dly_bits[2] ? HS_ACT : !HS_ACT;
    vsync_d = dly_bits[1] ? VS_ACT : !VS_ACT;
    de_d    = dly_bits[0];
    rgb_d   = dly_bits[0] ? color_in : '0;
  end

  // Aligned output registers, advanced only on pixel ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= !HS_ACT;
      vsync_q <= !VS_ACT;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else if (!en) begin
      hsync_q <= !HS_ACT;
      vsync_q <= !VS_ACT;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else if (pe) begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign red       = rgb_q[3*CW-1:2*CW];
  assign green     = rgb_q[2*CW-1:CW];
  assign blue      = rgb_q[CW-1:0];
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_pipelined_controller.sv
// Directed bench for vga_pipelined_controller with a small 32x22 raster,
// CLK_DIV=2, LEAD=2 (line = 64 clk, frame = 1408 clk).
module tb_vga_pipelined_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [23:0] color_in;
  logic        req_valid, screenend, hsync, vsync, de;
  logic [9:0]  req_x, req_y;
  logic [15:0] frame_cnt;
  logic [7:0]  red, green, blue;

  int n_total = 0;
  int n_pass  = 0;
  int s       = 0;   // edges since the last reset release

  // pixel source: returns {x, y, 5A} two pixel ticks after the request
  logic        white = 1'b0;
  logic        tdiv;
  logic [23:0] src0, src1;

  vga_pipelined_controller #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(10), .V_FP(3), .V_SYNC(4), .V_BP(5),
    .CLK_DIV(2), .LEAD(2), .HS_POL(0), .VS_POL(0),
    .CW(8), .XW(10), .YW(10)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .color_in(color_in),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .screenend(screenend), .frame_cnt(frame_cnt),
    .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  assign color_in = white ? 24'hFFFFFF : src1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tdiv <= 1'b0;
      src0 <= '0;
      src1 <= '0;
    end else if (!en) begin
      tdiv <= 1'b0;
    end else if (tdiv) begin
      tdiv <= 1'b0;
      src1 <= src0;
      src0 <= {req_x[7:0], req_y[7:0], 8'h5A};
    end else begin
      tdiv <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at s=%0d: got %0h, expected %0h", name, s, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    s++;
    #1;
  endtask

  task automatic step_to(input int t);
    while (s < t) step();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
    chk({tag, "_screenend"}, 32'(screenend), 32'd0);
    chk({tag, "_req_x"}, 32'(req_x), 32'd0);
    chk({tag, "_req_y"}, 32'(req_y), 32'd0);
  endtask

  typedef struct {
    int          s;
    int          rx;
    int          ry;
    bit          rv;
    bit          de;
    bit          hs;
    bit          vs;
    logic [23:0] rgb;
    bit          se;
    int          fc;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int se_cnt, se_first, se_last, vs_low, de_runs, de_len, hs_runs, hs_len;
    int de_fall, blank_bad, white_bad;
    logic p_de, p_hs;

    //       s     rx  ry  rv  de  hs  vs  rgb          se  fc
    tbl[0]  = '{1,    0,  0,  1,  0,  1,  1,  24'h000000,  0,  0};
    tbl[1]  = '{2,    1,  0,  1,  0,  1,  1,  24'h000000,  0,  0};
    tbl[2]  = '{5,    2,  0,  1,  0,  1,  1,  24'h000000,  0,  0};
    tbl[3]  = '{6,    3,  0,  1,  1,  1,  1,  24'h00005A,  0,  0};
    tbl[4]  = '{7,    3,  0,  1,  1,  1,  1,  24'h00005A,  0,  0};
    tbl[5]  = '{8,    4,  0,  1,  1,  1,  1,  24'h01005A,  0,  0};
    tbl[6]  = '{44,  22,  0,  0,  1,  1,  1,  24'h13005A,  0,  0};
    tbl[7]  = '{46,  23,  0,  0,  0,  1,  1,  24'h000000,  0,  0};
    tbl[8]  = '{52,  26,  0,  0,  0,  0,  1,  24'h000000,  0,  0};
    tbl[9]  = '{59,  29,  0,  0,  0,  0,  1,  24'h000000,  0,  0};
    tbl[10] = '{60,  30,  0,  0,  0,  1,  1,  24'h000000,  0,  0};
    tbl[11] = '{208,  8,  3,  1,  1,  1,  1,  24'h05035A,  0,  0};
    tbl[12] = '{620, 22,  9,  0,  1,  1,  1,  24'h13095A,  0,  0};
    tbl[13] = '{646,  3, 10,  0,  0,  1,  1,  24'h000000,  0,  0};
    tbl[14] = '{838,  3, 13,  0,  0,  1,  0,  24'h000000,  0,  0};
    tbl[15] = '{1092, 2, 17,  0,  0,  1,  0,  24'h000000,  0,  0};
    tbl[16] = '{1094, 3, 17,  0,  0,  1,  1,  24'h000000,  0,  0};
    tbl[17] = '{1406,31, 21,  0,  0,  1,  1,  24'h000000,  0,  0};
    tbl[18] = '{1407,31, 21,  0,  0,  1,  1,  24'h000000,  1,  0};
    tbl[19] = '{1408, 0,  0,  1,  0,  1,  1,  24'h000000,  0,  1};
    tbl[20] = '{1414, 3,  0,  1,  1,  1,  1,  24'h00005A,  0,  1};

    // first reset, then reset again in the middle of a line
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    s = 0;
    step_to(20);
    chk("midline_de_before_rst", 32'(de), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s = 0;
    #1;
    chk("release_req_x", 32'(req_x), 32'd0);
    chk("release_req_y", 32'(req_y), 32'd0);

    // table-driven frame with the coordinate pattern source
    for (int i = 0; i < 21; i++) begin
      step_to(tbl[i].s);
      chk($sformatf("v%0d_req_x", i), 32'(req_x), 32'(tbl[i].rx));
      chk($sformatf("v%0d_req_y", i), 32'(req_y), 32'(tbl[i].ry));
      chk($sformatf("v%0d_req_valid", i), 32'(req_valid), 32'(tbl[i].rv));
      chk($sformatf("v%0d_de", i), 32'(de), 32'(tbl[i].de));
      chk($sformatf("v%0d_hsync", i), 32'(hsync), 32'(tbl[i].hs));
      chk($sformatf("v%0d_vsync", i), 32'(vsync), 32'(tbl[i].vs));
      chk($sformatf("v%0d_rgb", i), 32'({red, green, blue}), 32'(tbl[i].rgb));
      chk($sformatf("v%0d_screenend", i), 32'(screenend), 32'(tbl[i].se));
      chk($sformatf("v%0d_frame_cnt", i), 32'(frame_cnt), 32'(tbl[i].fc));
    end

    // white source: streaming timing and blanking over one full frame window
    white = 1'b1;
    step_to(2800);
    se_cnt = 0; se_first = -1; se_last = -1; vs_low = 0;
    de_runs = 0; de_len = 0; hs_runs = 0; hs_len = 0;
    de_fall = -1000; blank_bad = 0; white_bad = 0;
    p_de = de; p_hs = hsync;
    while (s < 4224) begin
      step();
      if (s == 2816) chk("frame_cnt_2", 32'(frame_cnt), 32'd2);
      if (screenend) begin
        se_cnt++;
        if (se_first < 0) se_first = s;
        se_last = s;
      end
      if (!vsync) vs_low++;
      if (!de && ({red, green, blue} != 24'h0)) blank_bad++;
      if (de && ({red, green, blue} != 24'hFFFFFF)) white_bad++;
      if (de) de_len++;
      if (de && !p_de) de_runs++;
      if (!de && p_de) begin
        chk("de_run_len", 32'(de_len), 32'd40);
        de_len = 0;
        de_fall = s;
      end
      if (!hsync) hs_len++;
      if (!hsync && p_hs) begin
        hs_runs++;
        if (s - de_fall < 64) chk("hs_fall_after_de_fall", 32'(s - de_fall), 32'd6);
      end
      if (hsync && !p_hs) begin
        chk("hs_low_len", 32'(hs_len), 32'd8);
        hs_len = 0;
        if (s - de_fall < 64) chk("hs_rise_after_de_fall", 32'(s - de_fall), 32'd14);
      end
      p_de = de;
      p_hs = hsync;
    end
    chk("screenend_count", 32'(se_cnt), 32'd2);
    chk("screenend_first", 32'(se_first), 32'd2815);
    chk("screenend_period", 32'(se_last - se_first), 32'd1408);
    chk("vsync_low_clks", 32'(vs_low), 32'd256);
    chk("de_lines", 32'(de_runs), 32'd10);
    chk("hsync_pulses", 32'(hs_runs), 32'd23);
    chk("blanked_rgb_zero", 32'(blank_bad), 32'd0);
    chk("active_rgb_white", 32'(white_bad), 32'd0);
    chk("frame_cnt_3", 32'(frame_cnt), 32'd3);

    // drop en at v=5, h=12 and resume
    step_to(4568);
    chk("pre_idle_req_x", 32'(req_x), 32'd12);
    chk("pre_idle_req_y", 32'(req_y), 32'd5);
    en = 1'b0;
    step();
    chk_idle("en_drop");
    chk("en_drop_frame_cnt", 32'(frame_cnt), 32'd3);
    repeat (3) step();
    chk("idle_req_x", 32'(req_x), 32'd0);
    chk("idle_de", 32'(de), 32'd0);
    chk("idle_frame_cnt", 32'(frame_cnt), 32'd3);
    en = 1'b1;
    s = 0;
    step();
    chk("resume_s1_req_x", 32'(req_x), 32'd0);
    chk("resume_s1_req_y", 32'(req_y), 32'd0);
    step();
    chk("resume_s2_req_x", 32'(req_x), 32'd1);
    step_to(5);
    chk("resume_s5_de", 32'(de), 32'd0);
    step();
    chk("resume_s6_de", 32'(de), 32'd1);
    chk("resume_s6_rgb", 32'({red, green, blue}), 32'hFFFFFF);
    chk("resume_frame_cnt", 32'(frame_cnt), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
